// File: rtl/synth_spi_pkg.sv
// synth_spi_pkg
// Shared definitions for the synth SPI command link. The master
// (spi_cmd_master) and the synth-side receive decoder both import this
// package, so opcode values and payload lengths are defined only here.
//   OP_*           opcode constants
//   spi_state_t    frame sequencing states of the master
//   op_data_bytes  payload byte count for an opcode (0 = illegal opcode)
package synth_spi_pkg;

    localparam logic [7:0] OP_FREQ  = 8'h01;
    localparam logic [7:0] OP_ENV   = 8'h02;
    localparam logic [7:0] OP_FREQ2 = 8'h03;
    localparam logic [7:0] OP_ENV2  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // A zero count doubles as the "illegal opcode" marker.
    function automatic logic [1:0] op_data_bytes(input logic [7:0] op);
        case (op)
            OP_FREQ, OP_FREQ2: return 2'd2;
            OP_ENV, OP_ENV2:   return 2'd1;
            default:           return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
// SCLK divider for spi_cmd_master. While en is high it counts CLK_DIV clk
// cycles per SCLK half-period and flags the cycle in which SCLK must rise
// or fall; the top level registers SCLK itself on those strobes. Dropping
// en restarts the divider with SCLK in its low phase.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   en     divider running (top level is shifting)
//   rise   SCLK goes high at the next clk edge
//   fall   SCLK goes low at the next clk edge
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall
);

    logic [15:0] div_cnt;
    logic        phase_high;
    logic        tick;

    assign tick = en && (div_cnt == 16'(CLK_DIV - 1));
    assign rise = tick && !phase_high;
    assign fall = tick && phase_high;

    // Half-period counter plus a record of which SCLK phase we are in, so the
    // first strobe after enabling is always a rise after a full low phase.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt    <= '0;
            phase_high <= 1'b0;
        end else if (tick) begin
            div_cnt    <= '0;
            phase_high <= !phase_high;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master
// SPI mode-0 command master for the synth. Each accepted command becomes one
// NSS-low frame: opcode byte, then one or two payload bytes, MSB first.
// Illegal opcodes are swallowed with a one-cycle err_op pulse.
// Optional feature: define SPI_CMD_MASTER_MISO_CAPTURE_EN to capture MISO
// bytes into rx_data/rx_valid; otherwise those outputs are tied to zero.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_data   opcode byte and 16-bit payload
//   spi_nss/sclk/mosi  SPI outputs (NSS active low)
//   spi_miso           SPI input
//   busy               frame in progress
//   err_op             one-cycle pulse on a rejected opcode
//   rx_data, rx_valid  last captured MISO byte and its strobe
module spi_cmd_master
    import synth_spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int NSS_SETUP = 2,
    parameter int NSS_GAP   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        spi_nss,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic        err_op,
    output logic [7:0]  rx_data,
    output logic        rx_valid
);

    spi_state_t  state;
    logic [23:0] shreg;
    logic [15:0] cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_target;
    logic [1:0]  cmd_bytes;
    logic        sclk_rise;
    logic        sclk_fall;

    assign cmd_bytes = op_data_bytes(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign spi_mosi  = shreg[23];

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_SHIFT),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Frame sequencer. The shift register is loaded left-justified, so MOSI
    // is simply its MSB; shifting on every falling edge empties it by the end
    // of the frame, which leaves MOSI low in HOLD, GAP and IDLE for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            spi_nss    <= 1'b1;
            spi_sclk   <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            bit_target <= '0;
            err_op     <= 1'b0;
        end else begin
            err_op <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        if (cmd_bytes == 2'd0) begin
                            err_op <= 1'b1;
                        end else begin
                            state      <= ST_SETUP;
                            spi_nss    <= 1'b0;
                            bit_target <= {cmd_bytes, 3'b000} + 5'd8;
                            shreg      <= (cmd_bytes == 2'd2) ? {cmd_op, cmd_data}
                                                              : {cmd_op, cmd_data[7:0], 8'h00};
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == 16'(NSS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        spi_sclk <= 1'b1;
                        bit_cnt  <= bit_cnt + 5'd1;
                    end else if (sclk_fall) begin
                        spi_sclk <= 1'b0;
                        shreg    <= {shreg[22:0], 1'b0};
                        if (bit_cnt == bit_target) begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == 16'(CLK_DIV - 1)) begin
                        cnt     <= '0;
                        spi_nss <= 1'b1;
                        state   <= ST_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == 16'(NSS_GAP - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    spi_nss <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPI_CMD_MASTER_MISO_CAPTURE_EN
    logic [6:0] rx_shift;

    // MISO is sampled on the same edge SCLK rises; the low three bits of the
    // pre-increment bit count identify the eighth bit of each byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == ST_SHIFT && sclk_rise) begin
                rx_shift <= {rx_shift[5:0], spi_miso};
                if (bit_cnt[2:0] == 3'd7) begin
                    rx_data  <= {rx_shift, spi_miso};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_miso;

    assign unused_miso = spi_miso;
    assign rx_data     = 8'h00;
    assign rx_valid    = 1'b0;
`endif

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal values are >= 2.
REQ-002 Parameter NSS_SETUP, default 2: clk cycles from NSS falling to the first SCLK rising-edge phase.
REQ-003 Parameter NSS_GAP, default 8: minimum clk cycles NSS stays high between frames.
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_op  in  8  opcode byte.
REQ-009 cmd_data  in  16  payload.
REQ-010 spi_nss  out  1  slave select, active low.
REQ-011 spi_sclk  out  1  serial clock.
REQ-012 spi_mosi  out  1  serial data to the synth.
REQ-013 spi_miso  in  1  serial data from the synth.
REQ-014 busy  out  1  frame in progress.
REQ-015 err_op  out  1  one-cycle pulse when an opcode is rejected.
REQ-016 rx_data  out  8  last captured MISO byte (macro only).
REQ-017 rx_valid  out  1  one-cycle strobe for rx_data (macro only).

Function
REQ-018 The block SHALL use SPI mode 0: SCLK idles low, MOSI changes while SCLK is low, the slave samples on the rising edge, and bits go MSB first.
REQ-019 Opcodes 0x01 (freq) and 0x03 (freq2) SHALL send 2 data bytes, cmd_data[15:8] then cmd_data[7:0].
REQ-020 Opcodes 0x02 (env) and 0x04 (env2) SHALL send 1 data byte, cmd_data[7:0].
REQ-021 Each frame SHALL be: opcode byte, then data bytes, contiguous, with no SCLK gap between bytes, all under one NSS-low period.
REQ-022 A command SHALL be accepted on a clk edge where cmd_valid && cmd_ready; the block captures cmd_op and cmd_data at that edge.
REQ-023 cmd_ready SHALL be 1 only in IDLE.
REQ-024 FSM states and transitions SHALL be:
- IDLE -> SETUP on acceptance of a legal opcode; NSS falls on that edge.
- SETUP: NSS_SETUP cycles -> SHIFT; MOSI holds the opcode MSB.
- SHIFT: SCLK toggles every CLK_DIV cycles; 8*(1+N) rising edges, where N is the data-byte count.
- After the final falling edge -> HOLD: CLK_DIV cycles, SCLK low -> GAP with NSS high.
- GAP: NSS_GAP cycles -> IDLE.
REQ-025 An illegal opcode (any value other than 0x01-0x04) SHALL be accepted, SHALL raise err_op for exactly 1 cycle, SHALL generate no NSS or SCLK activity, and the block SHALL remain in IDLE.
REQ-026 busy SHALL be 1 whenever state != IDLE.
REQ-027 MOSI SHALL be 0 outside SETUP, SHIFT and HOLD.
REQ-028 cmd_valid held high SHALL produce back-to-back frames separated by NSS high for exactly NSS_GAP+1 clk cycles (GAP plus the IDLE acceptance cycle).
REQ-029 Input changes while busy SHALL be ignored.
REQ-030 Bit and byte counters SHALL not wrap: the frame ends exactly at bit count 8*(1+N).

Reset
REQ-031 While reset is asserted, at the next clk edge: state = IDLE, spi_nss = 1, spi_sclk = 0, spi_mosi = 0, cmd_ready = 1, busy = 0, err_op = 0, rx_valid = 0, rx_data = 0x00.
REQ-032 Reset mid-frame SHALL abort the frame immediately with no HOLD or GAP.
REQ-033 The first command after reset release SHALL be accepted on the first clk edge with cmd_valid = 1.

Configuration
REQ-034 With SPI_CMD_MASTER_MISO_CAPTURE_EN defined, MISO SHALL be sampled on each SCLK rising edge; after every 8th bit, rx_data SHALL update and rx_valid SHALL pulse for 1 cycle, including for the opcode byte.
REQ-035 Without SPI_CMD_MASTER_MISO_CAPTURE_EN, spi_miso SHALL be unused and rx_data = 0, rx_valid = 0 constantly; the ports remain present.

Structure
REQ-036 Shared package synth_spi_pkg SHALL hold the opcode constants (OP_FREQ = 0x01, OP_ENV = 0x02, OP_FREQ2 = 0x03, OP_ENV2 = 0x04), the FSM state enum, and an opcode-to-data-byte-count function; the synth's SPI receive decode reuses it.
REQ-037 One sub-module, spi_sclk_gen, SHALL hold the CLK_DIV divider and emit rise/fall strobes; the shift register and FSM live in the top level.

Verification (CLK_DIV = 4, NSS_SETUP = 2, NSS_GAP = 8)
REQ-038 op 0x01, data 0x1234 -> NSS low, 24 rising edges, MOSI bits 0x01, 0x12, 0x34; first rise 2+4 cycles after NSS falls.
REQ-039 op 0x04, data 0xBEA5 -> 16 rising edges, MOSI bytes 0x04, 0xA5; the 0xBE byte is not sent.
REQ-040 op 0x07 -> err_op = 1 for 1 cycle, NSS stays 1, SCLK stays 0, cmd_ready = 1 on the next cycle.
REQ-041 cmd_valid held, ops 0x02 then 0x03 -> NSS high for exactly 9 cycles between frames, second frame 24 bits.
REQ-042 reset asserted at bit 10 of an 0x01 frame -> next cycle NSS = 1, SCLK = 0, busy = 0; a following 0x02/0x55 frame is correct.
REQ-043 With the macro, MISO looped from a model returning 0xA5, 0x3C, 0x0F -> three rx_valid pulses carrying those values; without the macro, rx_valid never asserts.
